control_unit_mc: RTL and testbench

Parametrised multi-cycle control sequencer for the small microprocessor. It replaces the fixed IDLE/FETCH/DECODE/EXECUTE/HALT sequencer with five additions:
- explicit start
- instruction-memory ready handshake with fetch timeout and FAULT state
- variable-length EXECUTE driven by the decoder
- resume from HALT/FAULT
- retired-instruction counter

It drives the enables for PC, instruction register, decoder and datapath.

---
 rtl/control_unit_mc_if.sv | 49 ++++
 rtl/control_unit_mc.sv | 116 +++++++++++
 tb/tb_control_unit_mc.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/control_unit_mc_if.sv
// Bus bundle for control_unit_mc: sequencing inputs from the core plus the
// state/enable/counter outputs. The step_mode/step pair exists only when
// CU_SINGLE_STEP_EN is defined.
interface control_unit_mc_if #(
    parameter int unsigned STATE_W     = 3,
    parameter int unsigned EXEC_CNT_W  = 4,
    parameter int unsigned INSTR_CNT_W = 16
);
    logic                   start;
    logic                   stop_signal;
    logic                   mem_ready;
    logic [EXEC_CNT_W-1:0]  exec_cycles;
    logic                   resume;
`ifdef CU_SINGLE_STEP_EN
    logic                   step_mode;
    logic                   step;
`endif
    logic [STATE_W-1:0]     state;
    logic                   fetch_req;
    logic                   decode_en;
    logic                   exec_en;
    logic                   exec_last;
    logic                   pc_inc;
    logic                   halted;
    logic                   fault;
    logic [INSTR_CNT_W-1:0] retired;

    modport master (
`ifdef CU_SINGLE_STEP_EN
        output step_mode, output step,
`endif
        output start, output stop_signal, output mem_ready,
        output exec_cycles, output resume,
        input  state, input fetch_req, input decode_en, input exec_en,
        input  exec_last, input pc_inc, input halted, input fault,
        input  retired
    );

    modport slave (
`ifdef CU_SINGLE_STEP_EN
        input  step_mode, input step,
`endif
        input  start, input stop_signal, input mem_ready,
        input  exec_cycles, input resume,
        output state, output fetch_req, output decode_en, output exec_en,
        output exec_last, output pc_inc, output halted, output fault,
        output retired
    );
endinterface

// File: rtl/control_unit_mc.sv
// control_unit_mc: multi-cycle IDLE/FETCH/DECODE/EXECUTE/HALT/FAULT sequencer
// with start, fetch-ready handshake and timeout, decoder-driven execute
// length, resume, and a wrapping retired-instruction counter.
// Optional macro CU_SINGLE_STEP_EN adds the PAUSE state (step_mode/step).
module control_unit_mc #(
    parameter int unsigned STATE_W       = 3,
    parameter int unsigned EXEC_CNT_W    = 4,
    parameter int unsigned FETCH_TIMEOUT = 15,
    parameter int unsigned INSTR_CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    control_unit_mc_if.slave bus
);
    localparam int unsigned WAIT_W = $clog2(FETCH_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        HALT    = 3'd4,
        FAULT   = 3'd5,
        PAUSE   = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [EXEC_CNT_W-1:0]  exec_q, exec_d;
    logic [INSTR_CNT_W-1:0] retired_q, retired_d;
    logic                   last_w;

    // State, counters and retired count; reset dominates everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            exec_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            exec_q    <= exec_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and counter update. The wait counter defaults to zero so it
    // is cleared on every entry into FETCH, including resume from FAULT.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        exec_d    = exec_q;
        retired_d = retired_q;
        last_w    = (state_q == EXECUTE) && (exec_q == EXEC_CNT_W'(1));
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = FETCH;
            end
            FETCH: begin
                if (bus.mem_ready) begin
                    state_d = DECODE;
                end else if (wait_q == WAIT_W'(FETCH_TIMEOUT)) begin
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DECODE: begin
                exec_d  = (bus.exec_cycles == '0) ? EXEC_CNT_W'(1) : bus.exec_cycles;
                state_d = EXECUTE;
            end
            EXECUTE: begin
                exec_d = exec_q - EXEC_CNT_W'(1);
                if (last_w) begin
                    retired_d = retired_q + INSTR_CNT_W'(1);
                    // stop takes precedence over single-step pause
                    if (bus.stop_signal) begin
                        state_d = HALT;
`ifdef CU_SINGLE_STEP_EN
                    end else if (bus.step_mode) begin
                        state_d = PAUSE;
`endif
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                if (bus.resume) state_d = FETCH;
            end
            FAULT: begin
                if (bus.resume) state_d = FETCH;
            end
`ifdef CU_SINGLE_STEP_EN
            PAUSE: begin
                if (bus.step) state_d = FETCH;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output decode of the registered state and exec counter.
    always_comb begin
        bus.state     = STATE_W'(state_q);
        bus.fetch_req = (state_q == FETCH);
        bus.decode_en = (state_q == DECODE);
        bus.exec_en   = (state_q == EXECUTE);
        bus.exec_last = last_w;
        bus.pc_inc    = last_w;
        bus.halted    = (state_q == HALT);
        bus.fault     = (state_q == FAULT);
        bus.retired   = retired_q;
    end
endmodule

// File: tb/tb_control_unit_mc.sv
// Directed scoreboard bench for control_unit_mc. Each step drives inputs,
// pushes the expected post-edge outputs, then pops and compares after the edge.
// The retired counter is built 8 bits wide so the wrap fits in a short run.
module tb_control_unit_mc;
    localparam int unsigned SW = 3;
    localparam int unsigned EW = 4;
    localparam int unsigned IW = 8;

    typedef struct {
        string          tag;
        logic [2:0]     st;
        logic           last;
        logic [IW-1:0]  ret;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   r;
    exp_t sb[$];

    control_unit_mc_if #(.STATE_W(SW), .EXEC_CNT_W(EW), .INSTR_CNT_W(IW)) bus ();

    control_unit_mc #(
        .STATE_W(SW), .EXEC_CNT_W(EW), .FETCH_TIMEOUT(15), .INSTR_CNT_W(IW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] exp_vec(input logic [2:0] st, input logic last,
                                            input logic [IW-1:0] ret);
        return {st, st == 3'd1, st == 3'd2, st == 3'd3, last, last,
                st == 3'd4, st == 3'd5, ret};
    endfunction

    task automatic tick(input string tag, input logic [2:0] st, input logic last,
                        input int ret);
        exp_t e;
        logic [17:0] obs;
        logic [17:0] expv;
        e.tag = tag; e.st = st; e.last = last; e.ret = IW'(ret);
        sb.push_back(e);
        @(posedge clk);
        #1;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e    = sb.pop_front();
            expv = exp_vec(e.st, e.last, e.ret);
            obs  = {bus.state, bus.fetch_req, bus.decode_en, bus.exec_en,
                    bus.exec_last, bus.pc_inc, bus.halted, bus.fault, bus.retired};
            assert (obs === expv) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, expv);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; r = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.stop_signal = 1'b0; bus.mem_ready = 1'b0;
        bus.exec_cycles = '0; bus.resume = 1'b0;
`ifdef CU_SINGLE_STEP_EN
        bus.step_mode = 1'b0; bus.step = 1'b0;
`endif
        tick("reset", 3'd0, 1'b0, 0);
        reset = 1'b0;
        tick("idle_hold", 3'd0, 1'b0, 0);

        // back-to-back single-cycle instructions
        bus.start = 1'b1; bus.mem_ready = 1'b1; bus.exec_cycles = 4'd1;
        tick("start", 3'd1, 1'b0, 0);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick("t1_dec", 3'd2, 1'b0, r);
            tick("t1_exe", 3'd3, 1'b1, r);
            r++;
            tick("t1_fet", 3'd1, 1'b0, r);
        end

        // delayed mem_ready, 3-cycle execute, then exec_cycles=0
        bus.mem_ready = 1'b0; bus.exec_cycles = 4'd3;
        tick("t2_wait1", 3'd1, 1'b0, r);
        tick("t2_wait2", 3'd1, 1'b0, r);
        bus.mem_ready = 1'b1;
        tick("t2_dec", 3'd2, 1'b0, r);
        tick("t2_exe3", 3'd3, 1'b0, r);
        tick("t2_exe2", 3'd3, 1'b0, r);
        tick("t2_exe1", 3'd3, 1'b1, r);
        r++;
        bus.exec_cycles = 4'd0;
        tick("t2_fet", 3'd1, 1'b0, r);
        tick("t2_dec0", 3'd2, 1'b0, r);
        tick("t2_exe0", 3'd3, 1'b1, r);
        r++;
        tick("t2_fet0", 3'd1, 1'b0, r);

        // stop ignored until final execute cycle, then halt and resume
        bus.exec_cycles = 4'd3;
        tick("t4_dec", 3'd2, 1'b0, r);
        bus.stop_signal = 1'b1;
        tick("t4_exe3", 3'd3, 1'b0, r);
        tick("t4_exe2", 3'd3, 1'b0, r);
        tick("t4_exe1", 3'd3, 1'b1, r);
        r++;
        tick("t4_halt", 3'd4, 1'b0, r);
        bus.stop_signal = 1'b0; bus.start = 1'b1;
        tick("t4_halt_start", 3'd4, 1'b0, r);
        bus.start = 1'b0; bus.resume = 1'b1;
        tick("t4_resume", 3'd1, 1'b0, r);
        bus.resume = 1'b0;

        // fetch timeout into FAULT after 16 fetch cycles
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick("t3_wait", 3'd1, 1'b0, r);
        tick("t3_fault", 3'd5, 1'b0, r);
        bus.start = 1'b1; bus.stop_signal = 1'b1;
        tick("t3_fault_hold", 3'd5, 1'b0, r);
        bus.start = 1'b0; bus.stop_signal = 1'b0; bus.resume = 1'b1;
        tick("t3_resume", 3'd1, 1'b0, r);
        bus.resume = 1'b0;
        for (int i = 0; i < 15; i++) tick("t3_wait_b", 3'd1, 1'b0, r);
        bus.mem_ready = 1'b1; bus.exec_cycles = 4'd2;
        tick("t3_ready_at_limit", 3'd2, 1'b0, r);
        tick("t5_exe2", 3'd3, 1'b0, r);

        // reset mid-execute: no partial retire, everything cleared
        reset = 1'b1;
        r = 0;
        tick("t5_reset", 3'd0, 1'b0, r);
        reset = 1'b0;

        // retired wraps at all-ones
        bus.start = 1'b1; bus.exec_cycles = 4'd1;
        tick("t5_start", 3'd1, 1'b0, r);
        bus.start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tick("t5_dec", 3'd2, 1'b0, r);
            tick("t5_exe", 3'd3, 1'b1, r);
            r = (r + 1) % 256;
            tick("t5_fet", 3'd1, 1'b0, r);
        end

`ifdef CU_SINGLE_STEP_EN
        bus.step_mode = 1'b1;
        tick("t6_dec", 3'd2, 1'b0, r);
        tick("t6_exe", 3'd3, 1'b1, r);
        r++;
        tick("t6_pause", 3'd6, 1'b0, r);
        bus.resume = 1'b1;
        tick("t6_pause_resume", 3'd6, 1'b0, r);
        bus.resume = 1'b0; bus.step = 1'b1;
        tick("t6_step", 3'd1, 1'b0, r);
        bus.step = 1'b0;
        tick("t6_dec2", 3'd2, 1'b0, r);
        bus.stop_signal = 1'b1;
        tick("t6_exe2", 3'd3, 1'b1, r);
        r++;
        tick("t6_halt", 3'd4, 1'b0, r);
        bus.stop_signal = 1'b0; bus.resume = 1'b1;
        tick("t6_resume", 3'd1, 1'b0, r);
        bus.resume = 1'b0;
        tick("t6_dec3", 3'd2, 1'b0, r);
        tick("t6_exe3", 3'd3, 1'b1, r);
        r++;
        tick("t6_pause2", 3'd6, 1'b0, r);
        reset = 1'b1;
        tick("t6_reset", 3'd0, 1'b0, 0);
        reset = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
